// File: rtl/frame_tx_pkg.sv
// rtl/frame_tx_pkg.sv - shared constants, state encoding and frame length helper for frame_tx
// Optional feature macro: FRAME_TX_CSUM_EN (adds one checksum byte per frame).
package frame_tx_pkg;

  localparam logic [7:0] HEAD_DEFAULT = 8'hCA;
  localparam logic [7:0] TAIL_DEFAULT = 8'hFE;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT
  } state_t;

  // Total bytes on the wire for one frame: HEAD + payload [+ CSUM] + TAIL.
  function automatic int frame_len(input int payload_bytes);
`ifdef FRAME_TX_CSUM_EN
    return payload_bytes + 3;
`else
    return payload_bytes + 2;
`endif
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// rtl/frame_fifo.sv - small synchronous frame FIFO with registered read data
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr, wdata   write request and payload word
//   rd, rdata   pop request; rdata is loaded with the head entry on the pop edge
//   full, empty occupancy flags
// A write while full is accepted when a pop happens in the same cycle.
module frame_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             rd_ok;
  logic             wr_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      rdata <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (rd_ok) begin
        rptr  <= rptr + (AW+1)'(1);
        // Reads the old entry even when a full-FIFO write targets the same slot.
        rdata <= mem[rptr[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - queued, paced byte serializer: HEAD, payload MSB-first, [CSUM], TAIL
// Optional feature macro: FRAME_TX_CSUM_EN (checksum byte = payload sum mod 256).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din, den    payload word and load strobe (loads are queued in frame_fifo)
//   dout        current frame byte, held between strobes
//   drdy        one-cycle strobe marking a valid dout byte
//   busy        frame in progress or frames queued
//   ovf         one-cycle pulse when a load is dropped on a full queue
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 6,
  parameter int         GAP           = 3300,
  parameter int         DEPTH         = 2,
  parameter logic [7:0] HEAD          = HEAD_DEFAULT,
  parameter logic [7:0] TAIL          = TAIL_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [8*PAYLOAD_BYTES-1:0] din,
  input  logic                       den,
  output logic [7:0]                 dout,
  output logic                       drdy,
  output logic                       busy,
  output logic                       ovf
);

  localparam int NBYTES = frame_len(PAYLOAD_BYTES);
  localparam int PW     = 8 * PAYLOAD_BYTES;
  localparam int SW     = 8 * NBYTES;
  localparam int PCW    = $clog2(GAP);
  localparam int BCW    = $clog2(NBYTES + 1);

  state_t          state;
  state_t          state_nxt;
  logic            pop;
  logic            full;
  logic            empty;
  logic [PW-1:0]   payload;
  logic [SW-1:0]   frame_img;
  logic [SW-1:0]   shreg;
  logic [BCW-1:0]  bcnt;
  logic [PCW-1:0]  pcnt;
  logic [7:0]      dout_q;

  frame_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (den),
    .wdata (din),
    .rd    (pop),
    .rdata (payload),
    .full  (full),
    .empty (empty)
  );

`ifdef FRAME_TX_CSUM_EN
  logic [7:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      csum = csum + payload[8*i +: 8];
    end
  end

  assign frame_img = {HEAD, payload, csum, TAIL};
`else
  assign frame_img = {HEAD, payload, TAIL};
`endif

  // A load is dropped only when the queue is full and no pop frees a slot.
  assign ovf  = den & full & ~pop;
  assign busy = (state != IDLE) | ~empty;
  // During SEND the byte goes out straight from the shift register so drdy and
  // dout line up; dout_q keeps it on the pins until the next SEND.
  assign dout = drdy ? shreg[SW-1 -: 8] : dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drdy      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = SEND;
      end
      SEND: begin
        drdy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (pcnt == PCW'(1)) begin
          state_nxt = (bcnt != '0) ? SEND : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      bcnt   <= '0;
      pcnt   <= '0;
      dout_q <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg <= frame_img;
          bcnt  <= BCW'(NBYTES);
        end
        SEND: begin
          dout_q <= shreg[SW-1 -: 8];
          shreg  <= shreg << 8;
          bcnt   <= bcnt - BCW'(1);
          // SEND plus GAP-1 WAIT cycles gives exactly GAP cycles per byte.
          pcnt   <= PCW'(GAP - 1);
        end
        WAIT: begin
          pcnt <= pcnt - PCW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx.sv
// tb/tb_frame_tx.sv - randomized self-checking bench for frame_tx against a timing/queue model
module tb_frame_tx;

  localparam int PB    = 6;
  localparam int GAP   = 10;
  localparam int DEPTH = 2;
`ifdef FRAME_TX_CSUM_EN
  localparam int NB = PB + 3;
`else
  localparam int NB = PB + 2;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            den   = 1'b0;
  logic [8*PB-1:0] din   = '0;
  logic [7:0]      dout;
  logic            drdy;
  logic            busy;
  logic            ovf;

  frame_tx #(
    .PAYLOAD_BYTES (PB),
    .GAP           (GAP),
    .DEPTH         (DEPTH),
    .HEAD          (8'hCA),
    .TAIL          (8'hFE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .den   (den),
    .dout  (dout),
    .drdy  (drdy),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    int load;
    int pop;
    int tail;
  } frm_t;

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } stb_t;

  frm_t       frames[$];
  stb_t       exp_q[$];
  logic [7:0] exp_dout  = 8'h00;
  logic       rej       = 1'b0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         n_strobes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a load in cycle c is accepted when fewer than DEPTH frames
  // are waiting, or one of them is popped in cycle c. A frame starts 3 cycles
  // after its load, but never earlier than GAP+2 cycles after the previous TAIL.
  function automatic bit model_load(input int c, input logic [8*PB-1:0] p);
    int         occ     = 0;
    bit         pop_now = 1'b0;
    int         start;
    logic [7:0] bytes[$];
    logic [7:0] sum     = 8'h00;
    stb_t       s;
    frm_t       f;
    foreach (frames[i]) begin
      if (frames[i].load < c && frames[i].pop >= c) occ++;
      if (frames[i].pop == c) pop_now = 1'b1;
    end
    if (occ >= DEPTH && !pop_now) return 1'b0;
    start = c + 3;
    if (frames.size() > 0 && frames[$].tail + GAP + 2 > start) start = frames[$].tail + GAP + 2;
    bytes.push_back(8'hCA);
    for (int i = PB - 1; i >= 0; i--) begin
      bytes.push_back(p[8*i +: 8]);
      sum += p[8*i +: 8];
    end
`ifdef FRAME_TX_CSUM_EN
    bytes.push_back(sum);
`endif
    bytes.push_back(8'hFE);
    for (int i = 0; i < NB; i++) begin
      s.cyc = start + i * GAP;
      s.b   = bytes[i];
      exp_q.push_back(s);
    end
    f.load = c;
    f.pop  = start - 2;
    f.tail = start + (NB - 1) * GAP;
    frames.push_back(f);
    return 1'b1;
  endfunction

  function automatic bit busy_exp(input int x);
    foreach (frames[i]) begin
      if (frames[i].load < x && x <= frames[i].tail + GAP - 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  initial forever begin
    bit exp_drdy;
    @(negedge clk);
    exp_drdy = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
    check("drdy", drdy, exp_drdy);
    if (exp_drdy) begin
      check("dout_strobe", dout, exp_q[0].b);
      exp_dout = exp_q[0].b;
      void'(exp_q.pop_front());
    end else begin
      check("dout_hold", dout, exp_dout);
    end
    if (drdy) n_strobes++;
    check("busy", busy, busy_exp(cyc));
    check("ovf", ovf, den & rej);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: holds den for exactly one cycle.
  task automatic drive_load(input logic [8*PB-1:0] p);
    den = 1'b1;
    din = p;
    rej = !model_load(cyc, p);
    tick();
    den = 1'b0;
    rej = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy_exp(cyc)) && n < bound) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_busy", busy, 1'b0);
    frames.delete();
  endtask

  initial begin
    int          base;
    int          n;
    int          gap;
    logic [63:0] r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_drdy", drdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // Idle: monitor requires outputs quiet for the whole stretch.
    repeat (1000) tick();

    // Single frame.
    drive_load(48'h123456070809);
    wait_drain(200);

    // Back-to-back loads; fourth one overflows.
    drive_load(48'hA1A2A3A4A5A6);
    drive_load(48'hB1B2B3B4B5B6);
    drive_load(48'hC1C2C3C4C5C6);
    drive_load(48'hD1D2D3D4D5D6);
    wait_drain(600);

    // Load during a frame.
    drive_load(48'h0102030405FF);
    repeat (35) tick();
    drive_load(48'h9988776655AA);
    wait_drain(400);

    // Reset after the third strobe with one frame queued.
    base = n_strobes;
    drive_load(48'h123456070809);
    drive_load(48'h5555AAAA5555);
    n = 0;
    while (n_strobes < base + 3 && n < 100) begin
      tick();
      n++;
    end
    check("third_strobe_seen", (n_strobes >= base + 3), 1'b1);
    @(posedge clk);
    #2;
    exp_q.delete();
    frames.delete();
    exp_dout = 8'h00;
    rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 8'h00);
    check("midrst_drdy", drdy, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ovf", ovf, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (200) tick();

    // Randomized loads, including bursts that hit the full queue.
    for (int k = 0; k < 25; k++) begin
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 120);
      repeat (gap) tick();
      r = {$urandom, $urandom};
      drive_load(r[8*PB-1:0]);
    end
    wait_drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_tx.md
# frame_tx

Parametrised successor to the fixed 8-byte frame serializer. It accepts a payload word on a load strobe and queues it in a small frame FIFO, so a load never aborts a frame in flight. It then emits HEAD, the payload bytes MSB-first, an optional checksum and TAIL, one byte per strobe at a fixed pacing interval. It sits between the receive-side field assembly (uid/zid/cnt/type/rssi) and the byte-wide UART/host transmitter.

## Interface
- PAYLOAD_BYTES, 6, payload length in bytes (≥1).
- GAP, 3300, clock cycles between consecutive byte strobes within a frame (≥2).
- DEPTH, 2, frame FIFO depth in frames (power of 2, ≥2).
- HEAD, 8'hCA, first byte of every frame.
- TAIL, 8'hFE, last byte of every frame.

- clk  in  1  single system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  8*PAYLOAD_BYTES  payload; din[8*PAYLOAD_BYTES-1 -: 8] is sent first.
- den  in  1  load strobe; din is sampled on every cycle den=1.
- dout  out  8  current frame byte; held between strobes.
- drdy  out  1  one-cycle strobe, dout valid.
- busy  out  1  FIFO non-empty or a frame is in progress.
- ovf  out  1  one-cycle pulse when a load is dropped because the FIFO is full.

## Operation
- Frame = HEAD, payload bytes MSB-first, [CSUM], TAIL.
- NBYTES = PAYLOAD_BYTES+2 (+1 with checksum).
- States:
  - IDLE: FIFO non-empty → pop → LOAD.
  - LOAD: shift register ← {HEAD, payload, [CSUM], TAIL}; byte counter ← NBYTES → SEND.
  - SEND: drive top byte on dout; drdy=1; shift by 8; decrement byte counter; pacing counter ← GAP-1 → WAIT.
  - WAIT: decrement pacing counter. At 1: byte counter ≠0 → SEND, else → IDLE.
- FIFO write on den when not full.
- FIFO write also proceeds when full and a pop happens in the same cycle (simultaneous pop frees a slot).
- Otherwise den is dropped and ovf pulses for that cycle.
- den never disturbs the frame currently being shifted.
- busy = (state≠IDLE) | FIFO non-empty.
- Pacing counter width is $clog2(GAP); byte counter width is $clog2(NBYTES+1). No wrap: counters are reloaded, never underflow.
- Reset (any time, including mid-frame):
  - FIFO empties, state → IDLE.
  - dout=0, drdy=0, busy=0, ovf=0 asynchronously.
  - A partly sent frame is lost and is not resumed.

## Timing
- den at edge t into an empty FIFO while IDLE:
  - Pop at t+1.
  - LOAD at t+2.
  - HEAD strobe (drdy=1) in the cycle after edge t+2.
  - First-byte latency is therefore 3 cycles.
- Strobes within a frame are exactly GAP cycles apart; the last strobe (TAIL) is at first strobe + (NBYTES-1)·GAP.
- Back-to-back frames: next HEAD strobe is exactly GAP+2 cycles after the previous TAIL strobe (WAIT to IDLE, then IDLE pop, then LOAD).
- drdy is never high for two consecutive cycles.
- dout changes only in SEND cycles.

## Configuration
- FRAME_TX_CSUM_EN defined:
  - One checksum byte is inserted between the last payload byte and TAIL.
  - The checksum is the sum of payload bytes modulo 256, HEAD excluded.
  - NBYTES = PAYLOAD_BYTES+3.
- Undefined: no checksum byte; NBYTES = PAYLOAD_BYTES+2; no checksum logic synthesised.

## Structure
- Package frame_tx_pkg holds:
  - HEAD/TAIL default constants.
  - The state enum (IDLE, LOAD, SEND, WAIT).
  - A constant function frame_len(PAYLOAD_BYTES) returning NBYTES under the macro.
- Sub-module frame_fifo: synchronous FIFO, width 8*PAYLOAD_BYTES, depth DEPTH, async active-low reset.
  - frame_fifo provides full/empty flags and accepts a write on full when a pop occurs in the same cycle.
- Top level holds the FSM, the shift register (8·NBYTES bits), both counters and the checksum adder.

## Test plan
Bench parameters PAYLOAD_BYTES=6, GAP=10, DEPTH=2.
- Single frame, no macro: din=48'h123456070809, den at edge t → strobes at cycles t+3, t+13, …, t+73 with bytes CA 12 34 56 07 08 09 FE; busy falls after the final WAIT.
- Single frame with FRAME_TX_CSUM_EN: same din → CA 12 34 56 07 08 09 B4 FE, 9 strobes spaced 10 cycles.
- Back-to-back load and overflow: den on edges t, t+1, t+2 (three distinct payloads) → no ovf; all three frames emitted in order; each HEAD is 12 cycles after the previous TAIL. A fourth den at t+3 → ovf=1 for one cycle and that payload is never sent.
- Load during frame: den mid-frame with a different payload → current frame bytes are unchanged; the new frame starts 12 cycles after TAIL.
- Reset mid-frame: assert rst_n=0 after the 3rd strobe with one frame queued → dout=0, drdy=0, busy=0 immediately; after release no strobe occurs until a new den.
- Idle check: no den for 1000 cycles after reset → drdy, ovf and busy stay 0, and dout stays 8'h00.
